ecdsa_reg_bank: RTL

//  Parametrised PIO register bank for the multi-channel ECDSA engine; replaces the single-register block.

---
 rtl/ecdsa_reg_bank.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ecdsa_reg_bank.sv
// PIO register bank for the multi-channel ECDSA engine: per-channel expiry times,
// sticky error status with mask/IRQ, and clear-on-read verify counters.
module ecdsa_reg_bank #(
    parameter int unsigned           PIO_NBITS  = 32,
    parameter int unsigned           ADDR_NBITS = 8,
    parameter int unsigned           NUM_CH     = 4,
    parameter int unsigned           EXP_NBITS  = 32,
    parameter logic [EXP_NBITS-1:0]  EXP_RST    = '0,
    parameter int unsigned           CNT_NBITS  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_div,
    input  logic                        reg_bs,
    input  logic                        reg_rd,
    input  logic                        reg_wr,
    input  logic [PIO_NBITS-1:0]        reg_addr,
    input  logic [PIO_NBITS-1:0]        reg_din,
    output logic                        pio_ack,
    output logic                        pio_rvalid,
    output logic [PIO_NBITS-1:0]        pio_rdata,
    output logic [NUM_CH*EXP_NBITS-1:0] default_exp_time,
    input  logic [NUM_CH-1:0]           err_in,
    input  logic [NUM_CH-1:0]           verify_done,
    output logic                        err_irq
);

    localparam int unsigned BASE_EXP = 'h00;
    localparam int unsigned BASE_ERR = 'h10;
    localparam int unsigned BASE_MSK = 'h11;
    localparam int unsigned BASE_CNT = 'h20;

    logic [EXP_NBITS-1:0] exp_time [NUM_CH];
    logic [CNT_NBITS-1:0] verify_cnt [NUM_CH];
    logic [NUM_CH-1:0]    err_status;
    logic [NUM_CH-1:0]    err_mask;
    logic                 pend_wr;
    logic                 pend_rd;

    logic [ADDR_NBITS-1:0] addr_c;
    logic                  wr_req_c;
    logic                  rd_req_c;
    logic [NUM_CH-1:0]     w1c_c;
    logic [PIO_NBITS-1:0]  rdata_c;
    logic                  unused_addr_c;

    assign addr_c        = reg_addr[ADDR_NBITS-1:0];
    assign unused_addr_c = ^reg_addr[PIO_NBITS-1:ADDR_NBITS];

    // Single outstanding request; a simultaneous read+write is a write.
    assign wr_req_c = reg_bs & reg_wr & ~pend_wr & ~pend_rd;
    assign rd_req_c = reg_bs & reg_rd & ~reg_wr & ~pend_wr & ~pend_rd;
    assign w1c_c    = (wr_req_c && addr_c == ADDR_NBITS'(BASE_ERR)) ? reg_din[NUM_CH-1:0] : '0;

    // Read mux over the current register map; unmapped addresses read 0.
    always_comb begin
        rdata_c = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (addr_c == ADDR_NBITS'(BASE_EXP + ch))
                rdata_c = PIO_NBITS'(exp_time[ch]);
            if (addr_c == ADDR_NBITS'(BASE_CNT + ch))
                rdata_c = PIO_NBITS'(verify_cnt[ch]);
        end
        if (addr_c == ADDR_NBITS'(BASE_ERR))
            rdata_c = PIO_NBITS'(err_status);
        if (addr_c == ADDR_NBITS'(BASE_MSK))
            rdata_c = PIO_NBITS'(err_mask);
    end

    always_comb begin
        default_exp_time = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++)
            default_exp_time[ch*EXP_NBITS +: EXP_NBITS] = exp_time[ch];
    end

    // Response handshake: responses only move on clk_div cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_wr    <= 1'b0;
            pend_rd    <= 1'b0;
            pio_ack    <= 1'b0;
            pio_rvalid <= 1'b0;
            pio_rdata  <= '0;
            err_irq    <= 1'b0;
        end else begin
            if (clk_div) begin
                pio_ack    <= pend_wr;
                pio_rvalid <= pend_rd;
            end
            if (wr_req_c)
                pend_wr <= 1'b1;
            else if (clk_div)
                pend_wr <= 1'b0;
            if (rd_req_c)
                pend_rd <= 1'b1;
            else if (clk_div)
                pend_rd <= 1'b0;
            if (rd_req_c)
                pio_rdata <= rdata_c;
            err_irq <= |(err_status & ~err_mask);
        end
    end

    // Error status/mask; a new error wins over a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_status <= '0;
            err_mask   <= '1;
        end else begin
            err_status <= (err_status & ~w1c_c) | err_in;
            if (wr_req_c && addr_c == ADDR_NBITS'(BASE_MSK))
                err_mask <= reg_din[NUM_CH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++)
                exp_time[ch] <= EXP_RST;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++)
                if (wr_req_c && addr_c == ADDR_NBITS'(BASE_EXP + ch))
                    exp_time[ch] <= reg_din[EXP_NBITS-1:0];
        end
    end

    // Saturating verify counters, cleared when their read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++)
                verify_cnt[ch] <= '0;
        end else begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                if (rd_req_c && addr_c == ADDR_NBITS'(BASE_CNT + ch))
                    verify_cnt[ch] <= CNT_NBITS'(verify_done[ch]);
                else if (verify_done[ch] && verify_cnt[ch] != '1)
                    verify_cnt[ch] <= verify_cnt[ch] + CNT_NBITS'(1);
            end
        end
    end

endmodule
